// File: rtl/ifetch_queue_if.sv
// Fetch-queue bundle: redirect, MMU request/response and decode-side signals.
// Latency: n/a (wiring only).
// Backpressure: decode stalls via dec_ready_i; the MMU paces fetches via mmu_valid_i.
interface ifetch_queue_if;
    logic        redir_i;
    logic [31:0] redir_pc_i;
    logic [31:0] mmu_addr_o;
    logic        mmu_ena_o;
    logic [31:0] mmu_data_i;
    logic        mmu_valid_i;
    logic        mmu_exc_i;
    logic [31:0] dec_inst_o;
    logic [31:0] dec_pc_o;
    logic        dec_exc_o;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic        empty_o;
    logic        full_o;

    modport master (
        input  redir_i, redir_pc_i, mmu_data_i, mmu_valid_i, mmu_exc_i, dec_ready_i,
        output mmu_addr_o, mmu_ena_o, dec_inst_o, dec_pc_o, dec_exc_o, dec_valid_o,
               empty_o, full_o
    );

    modport slave (
        output redir_i, redir_pc_i, mmu_data_i, mmu_valid_i, mmu_exc_i, dec_ready_i,
        input  mmu_addr_o, mmu_ena_o, dec_inst_o, dec_pc_o, dec_exc_o, dec_valid_o,
               empty_o, full_o
    );
endinterface

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: PC, one-at-a-time MMU fetch, DEPTH-entry decode FIFO, redirect squash.
// Latency: response to decode 1 cycle; 0 cycles from an empty FIFO when IFQ_BYPASS_EN is defined.
// Backpressure: a FIFO slot is reserved before issue, so fetching stops while decode holds the FIFO full.
module ifetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'hBFC00000
) (
    input  logic           clk,
    input  logic           rst,
    ifetch_queue_if.master ifq
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_P = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, DROP, HALT} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] addr_q;
    logic        ena_q;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;

    logic [31:0] mem_pc   [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic        mem_exc  [DEPTH];

    logic [AW:0] count;
    logic [AW:0] count_next;
    logic        fifo_empty;
    logic        fifo_full;
    logic        resp_ok;
    logic        byp_vld;
    logic        byp_take;
    logic        push;
    logic        pop;
    logic        slot_left;
    logic [31:0] redir_tgt;
    logic [31:0] pc_inc;

    assign count      = wr_ptr - rd_ptr;
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == DEPTH_P);
    assign redir_tgt  = ifq.redir_pc_i & ~32'd3;
    assign pc_inc     = pc + 32'd4;
    assign resp_ok    = (state == REQ) && ifq.mmu_valid_i && !ifq.redir_i;

`ifdef IFQ_BYPASS_EN
    assign byp_vld = resp_ok && fifo_empty;
`else
    assign byp_vld = 1'b0;
`endif
    // A bypassed response that decode accepts never touches the FIFO.
    assign byp_take   = byp_vld && ifq.dec_ready_i;
    assign push       = resp_ok && !byp_take;
    assign pop        = !fifo_empty && ifq.dec_ready_i && !ifq.redir_i;
    assign count_next = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    assign slot_left  = (count_next < DEPTH_P);

    assign ifq.mmu_addr_o = addr_q;
    assign ifq.mmu_ena_o  = ena_q;
    assign ifq.empty_o    = fifo_empty;
    assign ifq.full_o     = fifo_full;

    always_comb begin
        ifq.dec_valid_o = 1'b0;
        ifq.dec_inst_o  = 32'd0;
        ifq.dec_pc_o    = 32'd0;
        ifq.dec_exc_o   = 1'b0;
        if (byp_vld) begin
            ifq.dec_valid_o = 1'b1;
            ifq.dec_inst_o  = ifq.mmu_data_i;
            ifq.dec_pc_o    = pc;
            ifq.dec_exc_o   = ifq.mmu_exc_i;
        end else if (!fifo_empty) begin
            ifq.dec_valid_o = 1'b1;
            ifq.dec_inst_o  = mem_inst[rd_ptr[AW-1:0]];
            ifq.dec_pc_o    = mem_pc[rd_ptr[AW-1:0]];
            ifq.dec_exc_o   = mem_exc[rd_ptr[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc[wr_ptr[AW-1:0]]   <= pc;
            mem_inst[wr_ptr[AW-1:0]] <= ifq.mmu_data_i;
            mem_exc[wr_ptr[AW-1:0]]  <= ifq.mmu_exc_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            ena_q  <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (ifq.redir_i) begin
            pc     <= redir_tgt;
            rd_ptr <= wr_ptr;
            ena_q  <= 1'b1;
            // The MMU cannot abort, so an unanswered fetch keeps its address until it returns.
            if ((state == REQ || state == DROP) && !ifq.mmu_valid_i) begin
                state <= DROP;
            end else begin
                state  <= REQ;
                addr_q <= redir_tgt;
            end
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case (state)
                IDLE: begin
                    if (!fifo_full) begin
                        state  <= REQ;
                        ena_q  <= 1'b1;
                        addr_q <= pc;
                    end
                end
                REQ: begin
                    if (ifq.mmu_valid_i) begin
                        if (ifq.mmu_exc_i) begin
                            state <= HALT;
                            ena_q <= 1'b0;
                        end else begin
                            pc <= pc_inc;
                            if (slot_left) begin
                                addr_q <= pc_inc;
                            end else begin
                                state <= IDLE;
                                ena_q <= 1'b0;
                            end
                        end
                    end
                end
                DROP: begin
                    if (ifq.mmu_valid_i) begin
                        state  <= REQ;
                        addr_q <= pc;
                    end
                end
                HALT:    state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
